stream_demux_32: RTL and testbench
==================================

Name: stream_demux_32

Overview:
- 1-to-2 demultiplexer for 32-bit words; the inverse of the 2:1 32-bit select mux in the datapath.
- Each input word carries a select bit and is steered to output 0 or output 1.
- Both sides use valid/ready handshakes; each output has its own small FIFO, so one stalled consumer does not lose data.
- Sits between a single producer (e.g. ALU/result bus) and two consumers (e.g. register-file write path and memory write path).

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 4, entries per output FIFO; power of two, ≥2.
- CNT_W, 16, width of per-output delivered-word counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  0 → output 0, 1 → output 1.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  head of FIFO 0.
- out0_valid  output  1  FIFO 0 non-empty.
- out0_ready  input  1  consumer 0 takes the word.
- out1_data  output  WIDTH  head of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 takes the word.
- cnt0  output  CNT_W  words delivered on output 0.
- cnt1  output  CNT_W  words delivered on output 1.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - All FIFO pointers and occupancy are 0; storage is cleared to 0.
  - out*_valid=0, out*_data=0, cnt0=cnt1=0.
  - in_ready reflects the empty FIFOs (1) after reset is deasserted.
  - In-flight words are discarded when reset asserts mid-operation.
- in_ready = NOT full(FIFO[in_sel]). This is combinational on in_sel.
- The producer holds in_data and in_sel stable while in_valid=1 and in_ready=0.
- Push: in_valid && in_ready at a rising edge writes in_data into FIFO[in_sel].
- The unselected FIFO is never written.
- Pop: outN_valid && outN_ready at a rising edge removes the head and increments cntN.
- cntN wraps from 2^CNT_W−1 to 0.
- Latency: a word pushed at edge k appears on outN_data/outN_valid after edge k. There is no same-cycle bypass, including when the FIFO is empty.
- outN_data is the registered head (show-ahead). It is stable while outN_valid=1 and no pop occurs.
- Simultaneous push and pop on the same FIFO:
  - FIFO non-empty and not full: occupancy unchanged; order preserved.
  - FIFO full: in_ready=0, so no push that cycle even though a pop frees a slot. Full blocks push regardless of same-cycle pop.
  - FIFO empty: only a push is possible.
- The two FIFOs operate independently. A pop on one output while pushing to the other is legal every cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits, with range 0..DEPTH.
- out*_ready asserted while out*_valid=0 has no effect.
- in_valid=0 has no effect, whatever in_sel is.
- Sustained throughput: one word per cycle into any non-full FIFO, one word per cycle out of each non-empty FIFO.

Decomposition:
- Shared package holds the constants DEFAULT_WIDTH=32, DEFAULT_DEPTH=4, DEFAULT_CNT_W=16, and the select encodings SEL_OUT0=0, SEL_OUT1=1.
- One natural sub-module, demux_fifo: a synchronous show-ahead FIFO with push, pop, full, empty and head outputs, plus async active-low reset. It is instantiated twice.
- Top level holds the steering logic, in_ready generation and counters.

Test Plan:
- Reset then idle: rst_n low with random inputs → out0_valid=out1_valid=0, out*_data=0, cnt0=cnt1=0; after release in_ready=1.
- Steering: push 0xA5A5_0001 with sel=0, then 0x5A5A_0002 with sel=1, both readies=1 → out0 shows 0xA5A5_0001 one cycle after its push, out1 shows 0x5A5A_0002 one cycle after its push; cnt0=cnt1=1.
- Fill and backpressure: out0_ready=0, push 5 words with sel=0 (DEPTH=4) → in_ready falls after the 4th accept; 5th held. Raise out0_ready → words exit in order 1..4; the 5th is accepted the cycle after the first pop.
- Full plus simultaneous pop: FIFO 0 full, out0_ready=1 and in_valid=1 with sel=0 in the same cycle → no push that cycle, one pop; push occurs the next cycle.
- Independence: FIFO 0 full and stalled, stream 8 words with sel=1 → all 8 delivered on out1 in order; cnt1=8, cnt0 unchanged.
- Mid-operation reset: FIFO 1 holding 3 words, pulse rst_n low between edges → out1_valid drops immediately (async); after release FIFO 1 is empty and cnt1=0.

Source files
------------

// File: rtl/stream_demux_32_pkg.sv
// Shared constants for the 1-to-2 word demultiplexer and its output FIFOs.
package stream_demux_32_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Show-ahead synchronous FIFO: head is the registered oldest entry, no
// same-cycle bypass from push to head.
module demux_fifo
  import stream_demux_32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_32.sv
// 1-to-2 valid/ready word demultiplexer with a per-output FIFO and
// per-output delivered-word counters.
module stream_demux_32
  import stream_demux_32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;

  // Ready depends only on the selected FIFO, so a stalled consumer never
  // blocks traffic headed to the other output.
  assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;
  assign push0    = in_valid && in_ready && (in_sel == SEL_OUT0);
  assign push1    = in_valid && in_ready && (in_sel == SEL_OUT1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .head      (out0_data),
    .full      (full0),
    .empty     (empty0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .head      (out1_data),
    .full      (full1),
    .empty     (empty1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop0) cnt0 <= cnt0 + 1'b1;
      if (pop1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_32.sv
// Directed bench for stream_demux_32: steering, backpressure, independence,
// counter wrap and asynchronous reset.
module tb_stream_demux_32;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int total;
  int bad;
  int exp_cnt0;
  int exp_cnt1;

  stream_demux_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    in_data = $urandom;
    in_sel = 1'b1;
    in_valid = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random activity on the inputs
    step();
    in_data = $urandom;
    in_sel  = 1'b0;
    step();
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", out0_data, 32'd0);
    chk("rst_out1_data", out1_data, 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    chk("post_rst_ready_sel1", 32'(in_ready), 32'd1);
    exp_cnt0 = 0;
    exp_cnt1 = 0;

    // Steering
    step();
    in_sel = 1'b0; in_data = 32'hA5A5_0001; in_valid = 1'b1;
    #1;
    chk("steer_ready0", 32'(in_ready), 32'd1);
    step();
    chk("steer_out0_valid", 32'(out0_valid), 32'd1);
    chk("steer_out0_data", out0_data, 32'hA5A5_0001);
    chk("steer_out1_idle", 32'(out1_valid), 32'd0);
    in_sel = 1'b1; in_data = 32'h5A5A_0002;
    step();
    exp_cnt0++;
    chk("steer_out0_drained", 32'(out0_valid), 32'd0);
    chk("steer_out1_valid", 32'(out1_valid), 32'd1);
    chk("steer_out1_data", out1_data, 32'h5A5A_0002);
    in_valid = 1'b0;
    step();
    exp_cnt1++;
    chk("steer_cnt0", 32'(cnt0), 32'(exp_cnt0));
    chk("steer_cnt1", 32'(cnt1), 32'(exp_cnt1));
    chk("steer_out1_drained", 32'(out1_valid), 32'd0);

    // Fill FIFO 0 under backpressure
    out0_ready = 1'b0;
    in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'h1000_0000 + 32'(i);
      #1;
      chk("fill_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_data = 32'h1000_0005;
    #1;
    chk("full_ready_low", 32'(in_ready), 32'd0);
    chk("full_head", out0_data, 32'h1000_0001);
    step();
    chk("held_ready_low", 32'(in_ready), 32'd0);
    chk("held_head_stable", out0_data, 32'h1000_0001);
    chk("held_cnt0", 32'(cnt0), 32'(exp_cnt0));

    // Full plus simultaneous pop: pop happens, push does not
    out0_ready = 1'b1;
    #1;
    chk("full_pop_ready_low", 32'(in_ready), 32'd0);
    step();
    exp_cnt0++;
    chk("full_pop_head", out0_data, 32'h1000_0002);
    chk("full_pop_cnt0", 32'(cnt0), 32'(exp_cnt0));
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    step();
    exp_cnt0++;
    in_valid = 1'b0;
    chk("order_w3", out0_data, 32'h1000_0003);
    step();
    exp_cnt0++;
    chk("order_w4", out0_data, 32'h1000_0004);
    step();
    exp_cnt0++;
    chk("order_w5", out0_data, 32'h1000_0005);
    step();
    exp_cnt0++;
    chk("fill_drained", 32'(out0_valid), 32'd0);
    chk("fill_cnt0", 32'(cnt0), 32'(exp_cnt0));

    // Independence: FIFO 0 full and stalled, stream through FIFO 1
    out0_ready = 1'b0;
    in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'h2000_0000 + 32'(i);
      step();
    end
    in_sel = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      in_data = 32'h3000_0000 + 32'(j);
      #1;
      chk("indep_ready1", 32'(in_ready), 32'd1);
      step();
      if (j > 1) exp_cnt1++;
      chk("indep_out1_valid", 32'(out1_valid), 32'd1);
      chk("indep_out1_data", out1_data, 32'h3000_0000 + 32'(j));
    end
    in_valid = 1'b0;
    step();
    exp_cnt1++;
    chk("indep_cnt1", 32'(cnt1), 32'(exp_cnt1));
    chk("indep_cnt0", 32'(cnt0), 32'(exp_cnt0));
    chk("indep_out0_head", out0_data, 32'h2000_0001);
    chk("indep_out0_valid", 32'(out0_valid), 32'd1);
    in_sel = 1'b0;
    #1;
    chk("indep_ready0_low", 32'(in_ready), 32'd0);

    // Mid-operation async reset with FIFO 1 holding 3 words
    out1_ready = 1'b0;
    in_sel = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'h4000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_out1_valid", 32'(out1_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out1_valid", 32'(out1_valid), 32'd0);
    chk("async_out0_valid", 32'(out0_valid), 32'd0);
    chk("async_cnt1", 32'(cnt1), 32'd0);
    chk("async_out1_data", out1_data, 32'd0);
    step();
    rst_n = 1'b1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #1;
    chk("rerst_ready1", 32'(in_ready), 32'd1);
    chk("rerst_out1_valid", 32'(out1_valid), 32'd0);

    // Counter wrap on output 1
    out1_ready = 1'b1;
    in_sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h5000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_cnt1_pre", 32'(cnt1), 32'd15);
    chk("wrap_last_data", out1_data, 32'h5000_000F);
    step();
    chk("wrap_cnt1", 32'(cnt1), 32'd0);
    chk("wrap_cnt0", 32'(cnt0), 32'd0);
    chk("wrap_drained", 32'(out1_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
